// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset core: fetch/decode/exec/mem/wb with a sticky trap.
// Latency: CPI 4 for R-type/addi/sw, 5 for lw, 3 for branches and jumps (zero-wait memory).
// Backpressure: imem_req/dmem_req are held until ack; an optional wait counter traps on a stuck memory.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMEOUT_W   = 4,
  parameter bit EN_JAL      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        alu_zero,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_next,
  output logic [1:0]  reg_dst,
  output logic        alu_src,
  output logic [2:0]  alu_ctrl,
  output logic        reg_we,
  output logic [1:0]  reg_in,
  output logic        halted,
  output logic [1:0]  trap_cause
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  // Timeout fires in the cycle whose count would reach MEM_TIMEOUT, i.e. when the
  // counter already holds MEM_TIMEOUT-1 and the ack still has not arrived.
  localparam bit                   TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  logic [2:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           cause_q, cause_d;
  logic [5:0]           op_q, funct_q;

  // Only opcode and funct steer control; the register fields belong to the datapath.
  logic rdata_unused;
  assign rdata_unused = ^imem_rdata[25:6];

  logic is_r, is_add, is_sub, is_slt, is_jr;
  logic is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  logic is_alu_r, legal, to_hit;

  assign is_r     = (op_q == 6'h00);
  assign is_add   = is_r && (funct_q == 6'h20);
  assign is_sub   = is_r && (funct_q == 6'h22);
  assign is_slt   = is_r && (funct_q == 6'h2A);
  assign is_jr    = is_r && (funct_q == 6'h08);
  assign is_addi  = (op_q == 6'h08);
  assign is_lw    = (op_q == 6'h23);
  assign is_sw    = (op_q == 6'h2B);
  assign is_beq   = (op_q == 6'h04);
  assign is_bne   = (op_q == 6'h05);
  assign is_j     = (op_q == 6'h02);
  assign is_jal   = (op_q == 6'h03) && EN_JAL;
  assign is_alu_r = is_add || is_sub || is_slt;
  assign legal    = is_alu_r || is_jr || is_addi || is_lw || is_sw ||
                    is_beq || is_bne || is_j || is_jal;
  assign to_hit   = TO_EN && (cnt_q == TO_LAST);

  // Next-state, wait-counter and trap-cause selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_EXEC: begin
        cnt_d = '0;
        if (is_alu_r || is_addi) state_d = S_WB;
        else if (is_lw || is_sw) state_d = S_MEM;
        else                     state_d = S_FETCH;
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = is_sw ? S_FETCH : S_WB;
          cnt_d   = '0;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter and sticky trap cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Capture opcode/funct alongside the instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      funct_q <= '0;
    end else if (state_q == S_FETCH && imem_ack) begin
      op_q    <= imem_rdata[31:26];
      funct_q <= imem_rdata[5:0];
    end
  end

  // Datapath controls decoded from state, latched instruction and alu_zero.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_next    = 2'd0;
    reg_dst    = 2'd0;
    alu_src    = 1'b0;
    alu_ctrl   = 3'd0;
    reg_we     = 1'b0;
    reg_in     = 2'd0;
    halted     = 1'b0;
    trap_cause = cause_q;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      S_EXEC: begin
        if (is_alu_r) begin
          alu_ctrl = is_sub ? 3'd1 : (is_slt ? 3'd2 : 3'd0);
        end else if (is_addi || is_lw || is_sw) begin
          alu_src = 1'b1;
        end else if (is_beq || is_bne) begin
          alu_ctrl = 3'd1;
          pc_we    = 1'b1;
          pc_next  = ((is_beq && alu_zero) || (is_bne && !alu_zero)) ? 2'd1 : 2'd0;
        end else if (is_j) begin
          pc_we   = 1'b1;
          pc_next = 2'd2;
        end else if (is_jal) begin
          pc_we   = 1'b1;
          pc_next = 2'd2;
          reg_we  = 1'b1;
          reg_dst = 2'd2;
          reg_in  = 2'd2;
        end else if (is_jr) begin
          pc_we   = 1'b1;
          pc_next = 2'd3;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        alu_src  = 1'b1;
        pc_we    = is_sw && dmem_ack;
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        reg_in  = is_lw ? 2'd1 : 2'd0;
        reg_dst = is_r ? 2'd1 : 2'd0;
      end
      S_TRAP:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_next;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       reg_we;
    logic [1:0] reg_in;
    logic       halted;
    logic [1:0] trap_cause;
  } ctl_t;

  localparam logic [31:0] ADD  = 32'h00221820;
  localparam logic [31:0] SUB  = 32'h00221822;
  localparam logic [31:0] SLT  = 32'h0022182A;
  localparam logic [31:0] ADDI = 32'h20220005;
  localparam logic [31:0] LW   = 32'h8C430004;
  localparam logic [31:0] SW   = 32'hAC430004;
  localparam logic [31:0] BEQ  = 32'h10220003;
  localparam logic [31:0] BNE  = 32'h14220003;
  localparam logic [31:0] JMP  = 32'h08000010;
  localparam logic [31:0] JR   = 32'h03E00008;
  localparam logic [31:0] JAL  = 32'h0C000010;
  localparam logic [31:0] ILL  = 32'hFC000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack, dmem_ack, alu_zero;
  logic [31:0] imem_rdata;

  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src, reg_we, halted;
  logic [1:0] pc_next, reg_dst, reg_in, trap_cause;
  logic [2:0] alu_ctrl;

  logic       nj_imem_req, nj_dmem_req, nj_dmem_we, nj_ir_we, nj_pc_we, nj_alu_src, nj_reg_we, nj_halted;
  logic [1:0] nj_pc_next, nj_reg_dst, nj_reg_in, nj_trap_cause;
  logic [2:0] nj_alu_ctrl;

  ctl_t obs, nj_obs;
  assign obs    = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_next, reg_dst,
                   alu_src, alu_ctrl, reg_we, reg_in, halted, trap_cause};
  assign nj_obs = {nj_imem_req, nj_dmem_req, nj_dmem_we, nj_ir_we, nj_pc_we, nj_pc_next, nj_reg_dst,
                   nj_alu_src, nj_alu_ctrl, nj_reg_we, nj_reg_in, nj_halted, nj_trap_cause};

  multicycle_ctrl #(.MEM_TIMEOUT(15), .TIMEOUT_W(4), .EN_JAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .alu_zero(alu_zero),
    .ir_we(ir_we), .pc_we(pc_we), .pc_next(pc_next), .reg_dst(reg_dst),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl), .reg_we(reg_we), .reg_in(reg_in),
    .halted(halted), .trap_cause(trap_cause)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(15), .TIMEOUT_W(4), .EN_JAL(1'b0)) dut_nojal (
    .clk(clk), .rst_n(rst_n),
    .imem_req(nj_imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(nj_dmem_req), .dmem_we(nj_dmem_we), .dmem_ack(dmem_ack), .alu_zero(alu_zero),
    .ir_we(nj_ir_we), .pc_we(nj_pc_we), .pc_next(nj_pc_next), .reg_dst(nj_reg_dst),
    .alu_src(nj_alu_src), .alu_ctrl(nj_alu_ctrl), .reg_we(nj_reg_we), .reg_in(nj_reg_in),
    .halted(nj_halted), .trap_cause(nj_trap_cause)
  );

  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  ctl_t  exp_q[$];
  string tag_q[$];

  // Expected-output builders, one per FSM phase.
  function automatic ctl_t f_zero();
    ctl_t e = '0;
    return e;
  endfunction
  function automatic ctl_t f_fetch(input logic ack);
    ctl_t e = '0;
    e.imem_req = 1'b1; e.ir_we = ack;
    return e;
  endfunction
  function automatic ctl_t f_alu(input logic src, input logic [2:0] ctrl);
    ctl_t e = '0;
    e.alu_src = src; e.alu_ctrl = ctrl;
    return e;
  endfunction
  function automatic ctl_t f_wb(input logic [1:0] rin, input logic [1:0] rdst);
    ctl_t e = '0;
    e.reg_we = 1'b1; e.pc_we = 1'b1; e.reg_in = rin; e.reg_dst = rdst;
    return e;
  endfunction
  function automatic ctl_t f_br(input logic [1:0] pcn);
    ctl_t e = '0;
    e.alu_ctrl = 3'd1; e.pc_we = 1'b1; e.pc_next = pcn;
    return e;
  endfunction
  function automatic ctl_t f_jmp(input logic [1:0] pcn);
    ctl_t e = '0;
    e.pc_we = 1'b1; e.pc_next = pcn;
    return e;
  endfunction
  function automatic ctl_t f_jal();
    ctl_t e = '0;
    e.pc_we = 1'b1; e.pc_next = 2'd2; e.reg_we = 1'b1; e.reg_dst = 2'd2; e.reg_in = 2'd2;
    return e;
  endfunction
  function automatic ctl_t f_mem(input logic we, input logic pcw);
    ctl_t e = '0;
    e.dmem_req = 1'b1; e.dmem_we = we; e.alu_src = 1'b1; e.pc_we = pcw;
    return e;
  endfunction
  function automatic ctl_t f_trap(input logic [1:0] cause);
    ctl_t e = '0;
    e.halted = 1'b1; e.trap_cause = cause;
    return e;
  endfunction

  task automatic push(input string t, input ctl_t e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic chk(input string t, input logic [18:0] o, input logic [18:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  // Drive one cycle of inputs, compare against the next scoreboard entry at negedge.
  task automatic cyc(input logic ia, input logic [31:0] rd, input logic da, input logic z);
    ctl_t  e;
    string t;
    imem_ack = ia; imem_rdata = rd; dmem_ack = da; alu_zero = z;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $error("FAIL scoreboard_underflow observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, obs, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic alu_instr(input string t, input logic [31:0] ins, input logic src,
                           input logic [2:0] ctrl, input logic [1:0] rdst);
    push({t, "_fetch"}, f_fetch(1'b1));
    push({t, "_decode"}, f_zero());
    push({t, "_exec"}, f_alu(src, ctrl));
    push({t, "_wb"}, f_wb(2'd0, rdst));
    cyc(1'b1, ins, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic short_instr(input string t, input logic [31:0] ins, input logic z, input ctl_t ex);
    push({t, "_fetch"}, f_fetch(1'b1));
    push({t, "_decode"}, f_zero());
    push({t, "_exec"}, ex);
    cyc(1'b1, ins, 1'b0, z);
    repeat (2) cyc(1'b0, 32'h0, 1'b0, z);
  endtask

  task automatic reset_pulse(input string t);
    rst_n = 1'b0;
    #1;
    chk({t, "_async"}, obs, 19'h0);
    @(posedge clk); #1;
    chk({t, "_held"}, obs, 19'h0);
    rst_n = 1'b1;
    push({t, "_idle"}, f_zero());
    cyc(1'b1, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0; imem_rdata = 32'h0;
    #1;
    chk("reset_outputs", obs, 19'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_clocked", obs, 19'h0);
    chk("reset_nojal", nj_obs, 19'h0);
    rst_n = 1'b1;
    // IDLE with stray acks: must still just move to FETCH.
    push("idle", f_zero());
    cyc(1'b1, 32'h0, 1'b1, 1'b0);

    alu_instr("add", ADD, 1'b0, 3'd0, 2'd1);
    alu_instr("sub", SUB, 1'b0, 3'd1, 2'd1);
    alu_instr("slt", SLT, 1'b0, 3'd2, 2'd1);
    alu_instr("addi", ADDI, 1'b1, 3'd0, 2'd0);

    // lw with dmem_ack delayed 3 cycles; a stray imem_ack in MEM is ignored.
    push("lw_fetch", f_fetch(1'b1));
    push("lw_decode", f_zero());
    push("lw_exec", f_alu(1'b1, 3'd0));
    for (int i = 0; i < 4; i++) push("lw_mem", f_mem(1'b0, 1'b0));
    push("lw_wb", f_wb(2'd1, 2'd0));
    cyc(1'b1, LW, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    // sw with two imem wait states (stray dmem_ack ignored in FETCH), zero-wait dmem.
    push("sw_fetch_wait", f_fetch(1'b0));
    push("sw_fetch_wait", f_fetch(1'b0));
    push("sw_fetch", f_fetch(1'b1));
    push("sw_decode", f_zero());
    push("sw_exec", f_alu(1'b1, 3'd0));
    push("sw_mem", f_mem(1'b1, 1'b1));
    repeat (2) cyc(1'b0, SW, 1'b1, 1'b0);
    cyc(1'b1, SW, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    short_instr("beq_taken", BEQ, 1'b1, f_br(2'd1));
    short_instr("beq_not", BEQ, 1'b0, f_br(2'd0));
    short_instr("bne_taken", BNE, 1'b0, f_br(2'd1));
    short_instr("bne_not", BNE, 1'b1, f_br(2'd0));
    short_instr("j", JMP, 1'b0, f_jmp(2'd2));
    short_instr("jr", JR, 1'b0, f_jmp(2'd3));
    short_instr("jal", JAL, 1'b0, f_jal());
    chk("nojal_trap", nj_obs, f_trap(2'd1));

    // Illegal opcode: sticky trap, later acks change nothing.
    push("ill_fetch", f_fetch(1'b1));
    push("ill_decode", f_zero());
    for (int i = 0; i < 3; i++) push("ill_trap", f_trap(2'd1));
    cyc(1'b1, ILL, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, ADD, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("trap_reset_nojal", nj_obs, 19'h0);
    reset_pulse("trap_reset");

    // imem never acks: 15 req cycles, then TRAP cause 2.
    for (int i = 0; i < 15; i++) push("imem_wait", f_fetch(1'b0));
    push("imem_timeout", f_trap(2'd2));
    push("imem_timeout_sticky", f_trap(2'd2));
    repeat (17) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    reset_pulse("rst2");

    // Ack on the 15th cycle wins over the timeout.
    for (int i = 0; i < 14; i++) push("imem_late_wait", f_fetch(1'b0));
    repeat (14) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    alu_instr("late_add", ADD, 1'b0, 3'd0, 2'd1);

    // dmem never acks: 15 MEM cycles, then TRAP cause 3.
    push("dto_fetch", f_fetch(1'b1));
    push("dto_decode", f_zero());
    push("dto_exec", f_alu(1'b1, 3'd0));
    for (int i = 0; i < 15; i++) push("dmem_wait", f_mem(1'b0, 1'b0));
    push("dmem_timeout", f_trap(2'd3));
    cyc(1'b1, LW, 1'b0, 1'b0);
    repeat (18) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    reset_pulse("rst3");

    // Reset in the middle of MEM aborts the lw without any reg_we/pc_we.
    push("abort_fetch", f_fetch(1'b1));
    push("abort_decode", f_zero());
    push("abort_exec", f_alu(1'b1, 3'd0));
    push("abort_mem", f_mem(1'b0, 1'b0));
    push("abort_mem", f_mem(1'b0, 1'b0));
    cyc(1'b1, LW, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    reset_pulse("mem_reset");
    alu_instr("post_reset_add", ADD, 1'b0, 3'd0, 2'd1);

    chk("scoreboard_drained", 19'(exp_q.size()), 19'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
